mask_bound_extract_512bit: RTL and testbench
============================================

MASK_BOUND_EXTRACT_512BIT -- requirements
Module: mask_bound_extract_512bit

Interface
REQ-001 SHALL have parameter MASK_W, default 512, meaning mask width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 32, meaning bits scanned per cycle from each end.
REQ-003 SHALL have port i_clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port i_trig, input, 1, meaning single-cycle start pulse that captures i_mask.
REQ-006 SHALL have port i_mask, input, 512, meaning the mask to decode (MSB-side run plus LSB-side run of ones).
REQ-007 SHALL have port o_done, output, 1, meaning the result is valid; level signal.
REQ-008 SHALL have port o_bound_index_left, output, 9, meaning the count of consecutive ones from bit 511 downward.
REQ-009 SHALL have port o_bound_index_right, output, 9, meaning the count of consecutive ones from bit 0 upward.
REQ-010 SHALL have port o_full, output, 1, meaning all 512 bits are one.
REQ-011 SHALL have port o_err, output, 1, meaning a one lies between the two runs, so the mask is not a left/right bound mask.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, DONE; transitions are IDLE/DONE->SCAN on i_trig, and SCAN->DONE after 16 SCAN cycles.
REQ-013 SHALL register i_mask into an internal 512-bit register on the i_trig cycle (cycle 0); later changes to i_mask SHALL be ignored.
REQ-014 SHALL, in SCAN cycle k (k=0..15), examine left chunk bits [511-32k -: 32], right chunk bits [32k +: 32], and one chunk for popcount.
REQ-015 SHALL keep the left count active while every chunk scanned so far is all ones: add 32 per all-ones chunk, else add that chunk's leading-ones count and freeze; the right count works the same using trailing ones.
REQ-016 SHALL accumulate the total popcount (10 bit) over all 16 chunks.
REQ-017 SHALL, when internal left count == 512: drive o_full=1, o_bound_index_left=511, o_bound_index_right=511, o_err=0.
REQ-018 SHALL otherwise drive o_full=0, left/right outputs equal to the exact counts (each at most 511), and o_err=1 exactly when popcount != left+right.
REQ-019 SHALL assert o_done on the cycle after the last SCAN cycle, i.e. 17 cycles after the i_trig edge; o_done, index outputs, o_full and o_err SHALL then hold until the next accepted i_trig.
REQ-020 SHALL deassert o_done on the cycle after an accepted i_trig, and keep it low throughout SCAN.
REQ-021 SHALL ignore i_trig during SCAN; no restart, no recapture.
REQ-022 SHALL accept i_trig in DONE (back-to-back operation), with identical timing to IDLE.
REQ-023 SHALL keep result outputs stable (previous values) during SCAN; they update only on entry to DONE.

Reset
REQ-024 SHALL, while i_rst=1 (asynchronously), force the state to IDLE, o_done=0, both index outputs=0, o_full=0, o_err=0, and all counters and the captured mask to 0.
REQ-025 SHALL abort any scan on reset mid-operation with no partial result; the first i_trig after release SHALL behave normally.

Structure
REQ-026 SHALL place MASK_W, CHUNK_W, N_CHUNK=16, IDX_W=9 and the FSM state encodings in the shared package mask_gen_pkg.
REQ-027 SHALL use one sub-module, run_count_32bit: purely combinational, 32-bit input, outputs all_ones, leading_ones (6b), trailing_ones (6b), popcount (6b); three instances (left, right, popcount).

Verification
REQ-028 SHALL cover: i_mask=0, i_trig -> o_done high exactly 17 cycles later with left=0, right=0, o_full=0, o_err=0.
REQ-029 SHALL cover: top 100 ones plus bottom 37 ones -> left=100, right=37, o_err=0; also top 32 ones exactly plus bottom 64 ones (chunk boundaries) -> left=32, right=64, o_err=0.
REQ-030 SHALL cover: all ones -> o_full=1, left=511, right=511, o_err=0; also bits [511:1] ones with bit0=0 -> left=511, right=0, o_full=0, o_err=0.
REQ-031 SHALL cover: top 5 ones, bottom 3 ones, plus bit 200 set -> left=5, right=3, o_err=1.
REQ-032 SHALL cover: i_trig pulsed again at cycle 5 of SCAN with a different i_mask -> ignored; original result at cycle 17.
REQ-033 SHALL cover: i_rst pulsed at cycle 8 of SCAN -> o_done=0 and all outputs 0 immediately; a new i_trig yields the correct result 17 cycles later.

Source files
------------

// File: rtl/mask_gen_pkg.sv
// Shared constants and FSM encoding for the left/right bound-mask decoder.
//   MASK_W  : mask width in bits
//   CHUNK_W : bits examined per cycle from each end of the mask
//   N_CHUNK : scan cycles needed to cover the mask
//   IDX_W   : width of the reported bound indices
//   CNT_W   : width of the scan-cycle counter
package mask_gen_pkg;

  localparam int unsigned MASK_W  = 512;
  localparam int unsigned CHUNK_W = 32;
  localparam int unsigned N_CHUNK = 16;
  localparam int unsigned IDX_W   = 9;
  localparam int unsigned CNT_W   = $clog2(N_CHUNK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/run_count_32bit.sv
// Combinational run/population counter for one 32-bit chunk.
//   data          : chunk to examine
//   all_ones      : every bit of data is one
//   leading_ones  : consecutive ones from bit 31 downward (0..32)
//   trailing_ones : consecutive ones from bit 0 upward (0..32)
//   popcount      : number of set bits (0..32)
module run_count_32bit (
  input  logic [31:0] data,
  output logic        all_ones,
  output logic [5:0]  leading_ones,
  output logic [5:0]  trailing_ones,
  output logic [5:0]  popcount
);

  logic run_l;
  logic run_t;

  always_comb begin
    all_ones      = &data;
    leading_ones  = '0;
    trailing_ones = '0;
    popcount      = '0;
    run_l         = 1'b1;
    run_t         = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      // run_* stays high only while the unbroken run continues from its end
      run_l         = run_l & data[31 - i];
      run_t         = run_t & data[i];
      leading_ones  = leading_ones + {5'b0, run_l};
      trailing_ones = trailing_ones + {5'b0, run_t};
      popcount      = popcount + {5'b0, data[i]};
    end
  end

endmodule

// File: rtl/mask_bound_extract_512bit.sv
// Decodes a left/right bound mask (a run of ones from the MSB plus a run of
// ones from the LSB) over N_CHUNK cycles, scanning one chunk from each end
// per cycle and accumulating a total popcount to detect stray ones.
//   i_clk               : clock, rising edge
//   i_rst               : asynchronous active-high reset
//   i_trig              : start pulse, captures i_mask (ignored while scanning)
//   i_mask              : mask to decode
//   o_done              : result valid (level, held until next accepted i_trig)
//   o_bound_index_left  : ones counted from the MSB downward
//   o_bound_index_right : ones counted from the LSB upward
//   o_full              : every mask bit is one
//   o_err               : a one lies between the two runs
module mask_bound_extract_512bit
  import mask_gen_pkg::*;
#(
  parameter int unsigned MASK_W  = mask_gen_pkg::MASK_W,
  parameter int unsigned CHUNK_W = mask_gen_pkg::CHUNK_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_trig,
  input  logic [MASK_W-1:0] i_mask,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_bound_index_left,
  output logic [IDX_W-1:0]  o_bound_index_right,
  output logic              o_full,
  output logic              o_err
);

  localparam int unsigned CW = IDX_W + 1;  // counts reach MASK_W

  state_t              state;
  logic [MASK_W-1:0]   mask_q;
  logic [CNT_W-1:0]    scan_cnt;
  logic [CW-1:0]       left_cnt, right_cnt, pop_cnt;
  logic [CW-1:0]       left_nxt, right_nxt, pop_nxt;
  logic                left_act, right_act;
  logic [IDX_W-1:0]    base;
  logic [CHUNK_W-1:0]  left_chunk, right_chunk;
  logic [CW:0]         run_sum;

  logic                l_all, r_all;
  logic [5:0]          l_lead, r_trail, p_pop;
  logic [5:0]          l_unused_trail, l_unused_pop;
  logic [5:0]          r_unused_lead, r_unused_pop;
  logic                p_unused_all;
  logic [5:0]          p_unused_lead, p_unused_trail;

  // Left chunk [MASK_W-1-base -: CHUNK_W] expressed as an ascending select.
  assign base        = IDX_W'(scan_cnt) * IDX_W'(CHUNK_W);
  assign right_chunk = mask_q[base +: CHUNK_W];
  assign left_chunk  = mask_q[(IDX_W'(MASK_W - CHUNK_W) - base) +: CHUNK_W];

  run_count_32bit u_left (
    .data          (left_chunk),
    .all_ones      (l_all),
    .leading_ones  (l_lead),
    .trailing_ones (l_unused_trail),
    .popcount      (l_unused_pop)
  );

  run_count_32bit u_right (
    .data          (right_chunk),
    .all_ones      (r_all),
    .leading_ones  (r_unused_lead),
    .trailing_ones (r_trail),
    .popcount      (r_unused_pop)
  );

  run_count_32bit u_pop (
    .data          (right_chunk),
    .all_ones      (p_unused_all),
    .leading_ones  (p_unused_lead),
    .trailing_ones (p_unused_trail),
    .popcount      (p_pop)
  );

  // A run count keeps growing only while every chunk so far was all ones;
  // the first broken chunk contributes its partial run and freezes it.
  always_comb begin
    left_nxt  = left_cnt;
    right_nxt = right_cnt;
    if (left_act)
      left_nxt = left_cnt + (l_all ? CW'(CHUNK_W) : CW'(l_lead));
    if (right_act)
      right_nxt = right_cnt + (r_all ? CW'(CHUNK_W) : CW'(r_trail));
    pop_nxt = pop_cnt + CW'(p_pop);
    run_sum = {1'b0, left_nxt} + {1'b0, right_nxt};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= ST_IDLE;
      mask_q              <= '0;
      scan_cnt            <= '0;
      left_cnt            <= '0;
      right_cnt           <= '0;
      pop_cnt             <= '0;
      left_act            <= 1'b0;
      right_act           <= 1'b0;
      o_done              <= 1'b0;
      o_bound_index_left  <= '0;
      o_bound_index_right <= '0;
      o_full              <= 1'b0;
      o_err               <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_trig) begin
            state     <= ST_SCAN;
            mask_q    <= i_mask;
            scan_cnt  <= '0;
            left_cnt  <= '0;
            right_cnt <= '0;
            pop_cnt   <= '0;
            left_act  <= 1'b1;
            right_act <= 1'b1;
            o_done    <= 1'b0;
          end
        end
        ST_SCAN: begin
          left_cnt  <= left_nxt;
          right_cnt <= right_nxt;
          pop_cnt   <= pop_nxt;
          left_act  <= left_act & l_all;
          right_act <= right_act & r_all;
          scan_cnt  <= scan_cnt + 1'b1;
          if (scan_cnt == CNT_W'(N_CHUNK - 1)) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            if (left_nxt == CW'(MASK_W)) begin
              o_full              <= 1'b1;
              o_bound_index_left  <= '1;
              o_bound_index_right <= '1;
              o_err               <= 1'b0;
            end else begin
              o_full              <= 1'b0;
              o_bound_index_left  <= left_nxt[IDX_W-1:0];
              o_bound_index_right <= right_nxt[IDX_W-1:0];
              o_err               <= run_sum != {1'b0, pop_nxt};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_bound_extract_512bit.sv
// Randomized self-checking bench for mask_bound_extract_512bit with a
// bit-walking reference model of the bound-mask rules.
module tb_mask_bound_extract_512bit;

  typedef struct packed {
    logic [8:0] left;
    logic [8:0] right;
    logic       full;
    logic       err;
  } res_t;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_trig;
  logic [511:0] i_mask;
  logic         o_done;
  logic [8:0]   o_bound_index_left;
  logic [8:0]   o_bound_index_right;
  logic         o_full;
  logic         o_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t prev;

  mask_bound_extract_512bit #(.MASK_W(512), .CHUNK_W(32)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_trig              (i_trig),
    .i_mask              (i_mask),
    .o_done              (o_done),
    .o_bound_index_left  (o_bound_index_left),
    .o_bound_index_right (o_bound_index_right),
    .o_full              (o_full),
    .o_err               (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Walk the mask bit by bit from each end.
  function automatic res_t model(input logic [511:0] m);
    res_t r;
    int   l = 0, rr = 0, p = 0;
    for (int i = 511; i >= 0; i--) begin
      if (!m[i]) break;
      l++;
    end
    for (int i = 0; i < 512; i++) begin
      if (!m[i]) break;
      rr++;
    end
    for (int i = 0; i < 512; i++) p += int'(m[i]);
    if (l == 512) begin
      r.left = 9'd511; r.right = 9'd511; r.full = 1'b1; r.err = 1'b0;
    end else begin
      r.left = 9'(l); r.right = 9'(rr); r.full = 1'b0; r.err = (p != l + rr);
    end
    return r;
  endfunction

  function automatic logic [511:0] bmask(input int l, input int r);
    logic [511:0] m = '0;
    for (int i = 0; i < l; i++) m[511 - i] = 1'b1;
    for (int i = 0; i < r; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [511:0] rand_word_mask();
    logic [511:0] m;
    for (int w = 0; w < 16; w++) m[32*w +: 32] = $urandom();
    return m;
  endfunction

  task automatic check_outputs(input string tag, input res_t e, input logic done_exp);
    check_eq({tag, "_done"},  32'(o_done),              32'(done_exp));
    check_eq({tag, "_left"},  32'(o_bound_index_left),  32'(e.left));
    check_eq({tag, "_right"}, 32'(o_bound_index_right), 32'(e.right));
    check_eq({tag, "_full"},  32'(o_full),              32'(e.full));
    check_eq({tag, "_err"},   32'(o_err),               32'(e.err));
  endtask

  // One operation: trig captured at the end of cycle 0, SCAN cycles 1..16,
  // result visible in cycle 17. trig_at/rst_at inject a pulse in that SCAN cycle.
  task automatic run_op(input logic [511:0] m, input int trig_at, input int rst_at,
                        input string tag);
    res_t e;
    e = model(m);
    @(negedge i_clk);
    i_mask = m;
    i_trig = 1'b1;
    @(posedge i_clk);
    #1;
    i_trig = 1'b0;
    i_mask = rand_word_mask();
    for (int c = 1; c <= 16; c++) begin
      @(negedge i_clk);
      if (c == trig_at) begin
        i_trig = 1'b1;
        i_mask = ~m;
      end
      if (c == rst_at) begin
        i_rst = 1'b1;
        #1;
        prev = '0;
        check_outputs({tag, "_rst"}, prev, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        return;
      end
      @(posedge i_clk);
      #1;
      i_trig = 1'b0;
      check_eq({tag, "_done_c"}, 32'(o_done), 32'(c == 16));
      if (c == 4 || c == 12) begin
        check_eq({tag, "_hold_left"},  32'(o_bound_index_left),  32'(prev.left));
        check_eq({tag, "_hold_right"}, 32'(o_bound_index_right), 32'(prev.right));
        check_eq({tag, "_hold_flags"}, 32'({o_full, o_err}),     32'({prev.full, prev.err}));
      end
    end
    check_outputs(tag, e, 1'b1);
    prev = e;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq({tag, "_keep_done"}, 32'(o_done),             32'(1));
    check_eq({tag, "_keep_left"}, 32'(o_bound_index_left), 32'(e.left));
  endtask

  initial begin
    logic [511:0] m;
    int           l, r;
    i_rst  = 1'b1;
    i_trig = 1'b0;
    i_mask = '0;
    prev   = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_outputs("reset", prev, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs("idle", prev, 1'b0);

    run_op('0, 0, 0, "zero");
    run_op(bmask(100, 37), 0, 0, "l100_r37");
    run_op(bmask(32, 64), 0, 0, "l32_r64");
    run_op('1, 0, 0, "full");
    run_op(bmask(511, 0), 0, 0, "l511");
    m = bmask(5, 3);
    m[200] = 1'b1;
    run_op(m, 0, 0, "stray200");
    run_op(bmask(0, 511), 0, 0, "r511");

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) l = 32 * $urandom_range(0, 16);
      else l = $urandom_range(0, 512);
      r = (l >= 512) ? 0 : $urandom_range(0, 512 - l);
      m = bmask(l, r);
      if (l + r <= 509 && $urandom_range(0, 2) == 0)
        m[r + 1 + $urandom_range(0, 509 - l - r)] = 1'b1;
      run_op(m, 0, 0, "rand");
    end
    run_op(rand_word_mask(), 0, 0, "noise");

    run_op(bmask(70, 9), 5, 0, "retrig");
    run_op(bmask(12, 200), 0, 8, "midrst");
    run_op(bmask(12, 200), 0, 0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
